// File: rtl/game_pkg.sv
// Shared types and constants for the frame-rate game sequencer.
package game_pkg;

    localparam int LIVES_W = 4;
    localparam int TIMER_W = 8;

    localparam logic [7:0] KEY_START = 8'h28;
    localparam logic [7:0] KEY_PAUSE = 8'h13;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_READY     = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_PLAYING   = 3'd3,
        ST_DYING     = 3'd4,
        ST_RESPAWN   = 3'd5,
        ST_GAME_OVER = 3'd6,
        ST_WIN       = 3'd7
    } game_state_e;

endpackage

// File: rtl/game_flow_ctrl_key_edge_detect.sv
// Rising-edge detector for the start and pause keys across the four HID keycode bytes.
module key_edge_detect
    import game_pkg::*;
#(
    parameter logic [7:0] START_KEY = KEY_START,
    parameter logic [7:0] PAUSE_KEY = KEY_PAUSE
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [31:0] keycode,
    output logic        start_press,
    output logic        pause_press
);

    logic [31:0] prev_q;
    logic [31:0] prev_d;
    logic [3:0]  start_now;
    logic [3:0]  start_prev;
    logic [3:0]  pause_now;
    logic [3:0]  pause_prev;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign start_now[gi]  = (keycode[8*gi +: 8] == START_KEY);
            assign start_prev[gi] = (prev_q[8*gi +: 8]  == START_KEY);
            assign pause_now[gi]  = (keycode[8*gi +: 8] == PAUSE_KEY);
            assign pause_prev[gi] = (prev_q[8*gi +: 8]  == PAUSE_KEY);
        end
    endgenerate

    always_comb begin
        prev_d = keycode;
    end

    always_ff @(posedge clk) begin
        if (srst) prev_q <= '0;
        else      prev_q <= prev_d;
    end

    // A key moving between byte slots while held is not a new press.
    assign start_press = (|start_now) & ~(|start_prev);
    assign pause_press = (|pause_now) & ~(|pause_prev);

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-rate game sequencer: lives, timed READY/DYING/RESPAWN phases and relife strobe.
// Optional pause state is enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int         LIVES_INIT     = 3,
    parameter int         READY_FRAMES   = 120,
    parameter int         DYING_FRAMES   = 60,
    parameter int         RESPAWN_FRAMES = 30,
    parameter logic [7:0] START_KEY      = KEY_START,
    parameter logic [7:0] PAUSE_KEY      = KEY_PAUSE
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [31:0]        keycode,
    input  logic               player_hit,
    input  logic               level_clear,
    output logic [2:0]         game_state,
    output logic               relife,
    output logic [LIVES_W-1:0] lives,
    output logic [TIMER_W-1:0] phase_timer,
    output logic               play_en
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD   = LIVES_W'(LIVES_INIT);
    localparam logic [TIMER_W-1:0] READY_LOAD   = TIMER_W'(READY_FRAMES - 1);
    localparam logic [TIMER_W-1:0] DYING_LOAD   = TIMER_W'(DYING_FRAMES - 1);
    localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_FRAMES - 1);

    game_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               relife_q, relife_d;
    logic               play_en_q, play_en_d;
    logic               start_press;
    logic               pause_press;

    key_edge_detect #(
        .START_KEY (START_KEY),
        .PAUSE_KEY (PAUSE_KEY)
    ) u_keys (
        .clk         (frame_clk),
        .srst        (Reset),
        .keycode     (keycode),
        .start_press (start_press),
        .pause_press (pause_press)
    );

`ifndef GAME_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_press;
`endif

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= ST_TITLE;
            timer_q   <= '0;
            lives_q   <= LIVES_LOAD;
            relife_q  <= 1'b0;
            play_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lives_q   <= lives_d;
            relife_q  <= relife_d;
            play_en_q <= play_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TITLE:   if (start_press) state_d = ST_READY;
            ST_READY:   if (timer_q == '0) state_d = ST_PLAYING;
            ST_PLAYING: begin
                if (level_clear)     state_d = ST_WIN;
                else if (player_hit) state_d = ST_DYING;
`ifdef GAME_PAUSE_EN
                else if (pause_press) state_d = ST_PAUSED;
`endif
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED:  if (pause_press) state_d = ST_PLAYING;
`else
            ST_PAUSED:  state_d = ST_TITLE;
`endif
            ST_DYING: begin
                if (timer_q == '0) state_d = (lives_q != '0) ? ST_RESPAWN : ST_GAME_OVER;
            end
            ST_RESPAWN: if (timer_q == '0) state_d = ST_PLAYING;
            ST_GAME_OVER, ST_WIN: if (start_press) state_d = ST_READY;
            default:    state_d = ST_TITLE;
        endcase
    end

    // Timers load on entry to a timed state and count down while staying in it.
    always_comb begin
        timer_d = '0;
        lives_d = lives_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_READY:   timer_d = READY_LOAD;
                ST_DYING:   timer_d = DYING_LOAD;
                ST_RESPAWN: timer_d = RESPAWN_LOAD;
                default:    timer_d = '0;
            endcase
        end else if (state_q == ST_PAUSED) begin
            timer_d = timer_q;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        if (state_d == ST_READY && state_q != ST_READY)
            lives_d = LIVES_LOAD;
        else if (state_q == ST_PLAYING && state_d == ST_DYING)
            lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
    end

    always_comb begin
        relife_d  = (state_q == ST_DYING) && (state_d == ST_RESPAWN);
        play_en_d = (state_d == ST_PLAYING);
    end

    assign game_state  = state_q;
    assign relife      = relife_q;
    assign lives       = lives_q;
    assign phase_timer = timer_q;
    assign play_en     = play_en_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table plus long-phase sequences.
module tb_game_flow_ctrl;

`ifdef GAME_PAUSE_EN
    localparam bit PAUSE = 1'b1;
`else
    localparam bit PAUSE = 1'b0;
`endif

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [31:0] keycode;
    logic        player_hit;
    logic        level_clear;
    logic [2:0]  game_state;
    logic        relife;
    logic [3:0]  lives;
    logic [7:0]  phase_timer;
    logic        play_en;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] kc;
        logic        hit;
        logic        clr;
        logic [2:0]  st;
        logic [3:0]  lv;
        logic        rl;
        logic [7:0]  tm;
    } vec_t;

    vec_t vt [0:23];

    always #5 frame_clk = ~frame_clk;

    game_flow_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .player_hit  (player_hit),
        .level_clear (level_clear),
        .game_state  (game_state),
        .relife      (relife),
        .lives       (lives),
        .phase_timer (phase_timer),
        .play_en     (play_en)
    );

    task automatic tick(input logic [31:0] kc, input logic hit, input logic clr);
        @(negedge frame_clk);
        keycode     = kc;
        player_hit  = hit;
        level_clear = clr;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic [3:0] lv,
                             input logic rl, input logic [7:0] tm);
        check({name, ".state"},  32'(game_state),  32'(st));
        check({name, ".lives"},  32'(lives),       32'(lv));
        check({name, ".relife"}, 32'(relife),      32'(rl));
        check({name, ".timer"},  32'(phase_timer), 32'(tm));
        check({name, ".play"},   32'(play_en),     32'(st == 3'd3));
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            tick(vt[i].kc, vt[i].hit, vt[i].clr);
            check_all($sformatf("vec%0d", i), vt[i].st, vt[i].lv, vt[i].rl, vt[i].tm);
            $display("[TB] vec %0d kc=%08h hit=%0d clr=%0d -> state=%0d lives=%0d relife=%0d timer=%0d",
                     i, vt[i].kc, vt[i].hit, vt[i].clr, game_state, lives, relife, phase_timer);
        end
    endtask

    task automatic run_phase(input string name, input logic [31:0] kc, input logic hit, input int n,
                             input logic [2:0] st, input logic [3:0] lv, input bit timed, input int start);
        for (int i = 0; i < n; i++) begin
            tick(kc, hit, 1'b0);
            check_all($sformatf("%s[%0d]", name, i), st, lv, 1'b0, timed ? 8'(start - i) : 8'd0);
        end
        $display("[TB] phase %s: %0d frames in state %0d", name, n, st);
    endtask

    initial begin
        vt[0]  = '{32'h0000_0000, 1'b0, 1'b0, 3'd0, 4'd3, 1'b0, 8'd0};
        vt[1]  = '{32'h0000_0028, 1'b0, 1'b0, 3'd1, 4'd3, 1'b0, 8'd119};
        vt[2]  = '{32'h0000_0028, 1'b0, 1'b0, 3'd1, 4'd3, 1'b0, 8'd118};
        vt[3]  = '{32'h0000_2800, 1'b0, 1'b0, 3'd1, 4'd3, 1'b0, 8'd117};
        vt[4]  = '{32'h0000_0028, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0, 8'd0};
        vt[5]  = '{32'h0000_0000, 1'b1, 1'b0, 3'd4, 4'd2, 1'b0, 8'd59};
        vt[6]  = '{32'h0000_0000, 1'b0, 1'b0, 3'd5, 4'd2, 1'b1, 8'd29};
        vt[7]  = '{32'h0000_0000, 1'b0, 1'b0, 3'd3, 4'd2, 1'b0, 8'd0};
        vt[8]  = '{32'h0000_0000, 1'b1, 1'b0, 3'd4, 4'd1, 1'b0, 8'd59};
        vt[9]  = '{32'h0000_0000, 1'b0, 1'b0, 3'd5, 4'd1, 1'b1, 8'd29};
        vt[10] = '{32'h0000_0000, 1'b0, 1'b0, 3'd3, 4'd1, 1'b0, 8'd0};
        vt[11] = '{32'h0000_0000, 1'b1, 1'b0, 3'd4, 4'd0, 1'b0, 8'd59};
        vt[12] = '{32'h0000_0000, 1'b0, 1'b0, 3'd6, 4'd0, 1'b0, 8'd0};
        vt[13] = '{32'h0000_0028, 1'b0, 1'b0, 3'd1, 4'd3, 1'b0, 8'd119};
        vt[14] = '{32'h0000_0000, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0, 8'd0};
        vt[15] = '{32'h0000_0000, 1'b1, 1'b1, 3'd7, 4'd3, 1'b0, 8'd0};
        vt[16] = '{32'h0000_0000, 1'b1, 1'b0, 3'd7, 4'd3, 1'b0, 8'd0};
        vt[17] = '{32'h0028_0000, 1'b0, 1'b0, 3'd1, 4'd3, 1'b0, 8'd119};
        vt[18] = '{32'h0000_0000, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0, 8'd0};
        vt[19] = '{32'h0000_1300, 1'b0, 1'b0, PAUSE ? 3'd2 : 3'd3, 4'd3, 1'b0, 8'd0};
        vt[20] = '{32'h0000_1300, PAUSE, 1'b0, PAUSE ? 3'd2 : 3'd3, 4'd3, 1'b0, 8'd0};
        vt[21] = '{32'h0000_0000, PAUSE, PAUSE, PAUSE ? 3'd2 : 3'd3, 4'd3, 1'b0, 8'd0};
        vt[22] = '{32'h1300_0000, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0, 8'd0};
        vt[23] = '{32'h0000_0000, 1'b1, 1'b0, 3'd4, 4'd2, 1'b0, 8'd59};

        Reset = 1'b1; keycode = '0; player_hit = 1'b0; level_clear = 1'b0;
        tick(32'h0, 1'b0, 1'b0);
        tick(32'h0, 1'b0, 1'b0);
        check_all("reset", 3'd0, 4'd3, 1'b0, 8'd0);
        Reset = 1'b0;

        // Start pressed then held through READY and well into PLAYING.
        apply_vecs(0, 3);
        run_phase("ready_held", 32'h28, 1'b0, 117, 3'd1, 4'd3, 1'b1, 116);
        apply_vecs(4, 4);
        run_phase("play_held", 32'h28, 1'b0, 77, 3'd3, 4'd3, 1'b0, 0);

        // Three deaths: two respawns with hits ignored, then game over.
        apply_vecs(5, 5);
        run_phase("dying1", 32'h0, 1'b1, 59, 3'd4, 4'd2, 1'b1, 58);
        apply_vecs(6, 6);
        run_phase("respawn1", 32'h0, 1'b1, 29, 3'd5, 4'd2, 1'b1, 28);
        apply_vecs(7, 8);
        run_phase("dying2", 32'h0, 1'b0, 59, 3'd4, 4'd1, 1'b1, 58);
        apply_vecs(9, 9);
        run_phase("respawn2", 32'h0, 1'b0, 29, 3'd5, 4'd1, 1'b1, 28);
        apply_vecs(10, 11);
        run_phase("dying3", 32'h0, 1'b0, 59, 3'd4, 4'd0, 1'b1, 58);
        apply_vecs(12, 13);
        run_phase("ready2", 32'h0, 1'b0, 119, 3'd1, 4'd3, 1'b1, 118);

        // Clear beats hit, restart from WIN, then pause handling.
        apply_vecs(14, 17);
        run_phase("ready3", 32'h0, 1'b0, 119, 3'd1, 4'd3, 1'b1, 118);
        apply_vecs(18, 23);
        run_phase("dying4", 32'h0, 1'b0, 4, 3'd4, 4'd2, 1'b1, 58);

        // Reset mid-DYING with start held: history cleared so the held key reads as a press.
        Reset = 1'b1;
        tick(32'h28, 1'b0, 1'b0);
        check_all("reset_dying", 3'd0, 4'd3, 1'b0, 8'd0);
        $display("[TB] reset mid-DYING -> state=%0d lives=%0d", game_state, lives);
        Reset = 1'b0;
        tick(32'h28, 1'b0, 1'b0);
        check_all("post_reset_press", 3'd1, 4'd3, 1'b0, 8'd119);
        tick(32'h28, 1'b0, 1'b0);
        check_all("post_reset_hold", 3'd1, 4'd3, 1'b0, 8'd118);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
